// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES decrypt, one Feistel round per clock; straight_pbox is the f-function P stage.
// Latency: OUT_VALID rises 17 edges after the accepting edge; one block in flight at a time.
// Backpressure: IN_READY low from acceptance until DOUT is taken; DOUT/OUT_VALID hold while OUT_READY=0.
// Optional encrypt mode: define DES_CORE_ENC_MODE_EN to add the MODE port (1=encrypt, 0=decrypt).
// Bit order: vector MSB is DES bit 1, so DES bit n of a W-bit word sits at index W-n.

// straight_pbox: fixed 32-bit P permutation of the DES f-function.
// Latency: combinational, zero cycles.
// Backpressure: none, pure wiring.
module straight_pbox (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // Output bit j takes DES input bit P_T[j].
  always_comb begin
    dout = '0;
    for (int j = 0; j < 32; j++) dout[31-j] = din[32-P_T[j]];
  end
endmodule

// des_decrypt_core: IP, 16 rounds with subkeys rotated on the fly, then FP of the swapped halves.
// Latency: 17 edges accept-to-OUT_VALID (16 rounds plus the output edge).
// Backpressure: single-entry; the next block is accepted only after the output handshake.
module des_decrypt_core #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] DIN,
  input  logic [63:0] KEY,
`ifdef DES_CORE_ENC_MODE_EN
  input  logic        MODE,
`endif
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [63:0] DOUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);
  localparam int CW = $clog2(ROUNDS + 2);

  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                              12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                              24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                                26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                                51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Each S-box is 64 nibbles, row-major (row 0 col 0 first).
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
    return y;
  endfunction

  // Parity bits (DES 8,16,..,64) are not referenced by PC-1 and drop out here.
  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
    return y;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[47-j] = x[32-E_T[j]];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input int n, input logic [5:0] x);
    int idx;
    idx = 16 * int'({x[5], x[0]}) + int'(x[4:1]);
    return SBOX[n][255-4*idx -: 4];
  endfunction

  // Decrypt walks the schedule backwards with right rotations (round 1 uses K16 = PC-2 of PC-1 as-is);
  // encrypt uses the forward left-rotation schedule.
  function automatic logic [1:0] rot_amt(input logic [CW-1:0] cnt_v, input logic enc_v);
    int r;
    r = int'(cnt_v);
    if (r == 2 || r == 9 || r == 16) return 2'd1;
    if (r == 1) return enc_v ? 2'd1 : 2'd0;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt, input logic left);
    case ({left, amt})
      3'b001:  return {x[0], x[27:1]};
      3'b010:  return {x[1:0], x[27:2]};
      3'b101:  return {x[26:0], x[27]};
      3'b110:  return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    l_reg, r_reg;
  logic [27:0]    c_reg, d_reg;
  logic [27:0]    c_rot, d_rot;
  logic [47:0]    subkey, sbox_in;
  logic [31:0]    s_out, p_out;
  logic           enc;

`ifdef DES_CORE_ENC_MODE_EN
  logic mode_r;
  assign enc = mode_r;
`else
  assign enc = 1'b0;
`endif

  // Round datapath: rotate C/D, build the subkey, then E, key mix and S-boxes.
  always_comb begin
    c_rot   = rot28(c_reg, rot_amt(cnt, enc), enc);
    d_rot   = rot28(d_reg, rot_amt(cnt, enc), enc);
    subkey  = perm_pc2({c_rot, d_rot});
    sbox_in = expand(r_reg) ^ subkey;
    s_out   = '0;
    for (int i = 0; i < 8; i++) s_out[31-4*i -: 4] = sbox(i, sbox_in[47-6*i -: 6]);
  end

  straight_pbox u_pbox (
    .din  (s_out),
    .dout (p_out)
  );

  // Control FSM plus L/R/C/D state; the edge after the last round registers the swapped, FP'd result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      DOUT      <= '0;
      cnt       <= '0;
      l_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
`ifdef DES_CORE_ENC_MODE_EN
      mode_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            {l_reg, r_reg} <= perm_ip(DIN);
            {c_reg, d_reg} <= perm_pc1(KEY);
            cnt            <= CW'(1);
            IN_READY       <= 1'b0;
            state          <= ROUND;
`ifdef DES_CORE_ENC_MODE_EN
            mode_r         <= MODE;
`endif
          end
        end
        ROUND: begin
          if (cnt == CW'(ROUNDS + 1)) begin
            DOUT      <= perm_fp({r_reg, l_reg});
            OUT_VALID <= 1'b1;
            state     <= DONE;
          end else begin
            l_reg <= r_reg;
            r_reg <= l_reg ^ p_out;
            c_reg <= c_rot;
            d_reg <= d_rot;
            cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core: scoreboard bench for des_decrypt_core.
// Known-answer DES vectors, latency, backpressure, mid-operation reset, back-to-back acceptance.
// Inputs change 1 time unit after the rising edge; the output monitor samples on the falling edge.
module tb_des_decrypt_core;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] DIN, KEY, DOUT;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY;
`ifdef DES_CORE_ENC_MODE_EN
  logic        MODE;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc = 0;
  logic [63:0] sb[$];

  // Known-answer set: key, ciphertext, plaintext. Entries 2 and 5 are 1 and 4 with every parity bit flipped.
  logic [63:0] vk [6] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73, 64'h0F339333EB6C0C72,
                          64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h0101010101010101};
  logic [63:0] vd [6] = '{64'h85E813540F0AB405, 64'h0000000000000000, 64'h0000000000000000,
                          64'hC0999FDDE378D7ED, 64'h8CA64DE9C1B123A7, 64'h8CA64DE9C1B123A7};
  logic [63:0] ve [6] = '{64'h0123456789ABCDEF, 64'h8787878787878787, 64'h8787878787878787,
                          64'h596F7572206C6970, 64'h0000000000000000, 64'h0000000000000000};

  des_decrypt_core #(.ROUNDS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .DIN       (DIN),
    .KEY       (KEY),
`ifdef DES_CORE_ENC_MODE_EN
    .MODE      (MODE),
`endif
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DOUT      (DOUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output side: a handshake happens on the next edge; exactly one result must be outstanding.
  always @(negedge clk) begin
    if (rst_n && OUT_VALID && OUT_READY) begin
      hs_cyc = cyc + 1;
      check_eq("sb_depth", 64'(sb.size()), 64'd1);
      if (sb.size() != 0) check_eq("dout", DOUT, sb.pop_front());
    end
  end

  // Offer one block; returns the edge index it was accepted on. keep leaves IN_VALID asserted.
  task automatic send(input logic [63:0] k, input logic [63:0] d, input logic [63:0] e,
                      input bit keep, output int acc);
    KEY = k; DIN = d; IN_VALID = 1'b1;
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      if (IN_READY) begin
        @(posedge clk); #1;
        acc = cyc;
        sb.push_back(e);
        IN_VALID = keep;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("accepted", 64'(acc >= 0), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_b, lat, n;
    rst_n = 1'b0; DIN = '0; KEY = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;
`ifdef DES_CORE_ENC_MODE_EN
    MODE = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    check_eq("rst_in_ready", 64'(IN_READY), 64'd1);
    check_eq("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check_eq("rst_dout", DOUT, 64'd0);
    rst_n = 1'b1;

    // First block: OUT_VALID must appear on the 17th edge after acceptance.
    send(vk[0], vd[0], ve[0], 1'b0, acc);
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk); #1;
      if (OUT_VALID) break;
    end
    check_eq("latency", 64'(lat), 64'd17);
    wait_drain("drain_first");

    // Known-answer vectors including parity-flipped keys.
    for (int i = 1; i < 6; i++) begin
      send(vk[i], vd[i], ve[i], 1'b0, acc);
      wait_drain("drain_vec");
    end

    // Backpressure: hold OUT_READY low with junk offered on the input.
    OUT_READY = 1'b0;
    send(vk[0], vd[0], ve[0], 1'b0, acc);
    for (n = 0; n < 40 && !OUT_VALID; n++) begin
      @(posedge clk); #1;
    end
    check_eq("bp_valid_seen", 64'(OUT_VALID), 64'd1);
    for (int i = 0; i < 5; i++) begin
      IN_VALID = 1'b1; DIN = {$urandom, $urandom}; KEY = {$urandom, $urandom};
      @(posedge clk); #1;
      check_eq("bp_dout", DOUT, ve[0]);
      check_eq("bp_out_valid", 64'(OUT_VALID), 64'd1);
      check_eq("bp_in_ready", 64'(IN_READY), 64'd0);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_in_ready", 64'(IN_READY), 64'd1);
    check_eq("bp_release_out_valid", 64'(OUT_VALID), 64'd0);
    check_eq("bp_sb", 64'(sb.size()), 64'd0);

    // Reset during round 8: immediate return to reset values, partial result dropped.
    send(vk[1], vd[1], ve[1], 1'b0, acc);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", 64'(IN_READY), 64'd1);
    check_eq("abort_out_valid", 64'(OUT_VALID), 64'd0);
    check_eq("abort_dout", DOUT, 64'd0);
    sb = {};
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check_eq("abort_no_output", 64'(OUT_VALID), 64'd0);
    send(vk[3], vd[3], ve[3], 1'b0, acc);
    wait_drain("drain_after_abort");

    // Back-to-back with IN_VALID held: second block lands on the edge after the first handshake.
    send(vk[0], vd[0], ve[0], 1'b1, acc);
    send(vk[3], vd[3], ve[3], 1'b0, acc_b);
    check_eq("b2b_accept_edge", 64'(acc_b), 64'(hs_cyc + 1));
    wait_drain("drain_b2b");

`ifdef DES_CORE_ENC_MODE_EN
    MODE = 1'b1;
    send(vk[0], ve[0], vd[0], 1'b0, acc);
    MODE = 1'b0;
    wait_drain("drain_enc");
`endif

    check_eq("final_sb", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
